mem_io_bridge: RTL and testbench

Parametrised successor to the single-channel memory/IO steering path of the single-cycle core. It sits between the execute stage and the register-file write port on one side, and the data memory plus IO_CH memory-mapped IO channels on the other. Loads from data memory take a configurable number of wait states, and the bridge holds the core with `stall` while a load is in flight. IO writes land in per-channel output registers with a one-cycle strobe.

---
 rtl/mem_io_pkg.sv | 8 +
 rtl/mem_io_bridge_if.sv | 26 ++
 rtl/io_sync2.sv | 18 +
 rtl/mem_io_bridge.sv | 92 +++++++++
 tb/tb_mem_io_bridge.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared FSM states, IO base address and channel-index width helper for mem_io_bridge
package mem_io_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  localparam logic [31:0] IO_BASE = 32'hFFFFFC00;
  function automatic int ch_bits(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if: core, data-memory and IO-channel signals of mem_io_bridge
interface mem_io_bridge_if #(parameter int DATA_W = 32, parameter int IO_W = 24, parameter int IO_CH = 4);
  logic                  mem_read;
  logic                  mem_write;
  logic                  io_read;
  logic                  io_write;
  logic [DATA_W-1:0]     addr_in;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     r_wdata;
  logic                  stall;
  logic [DATA_W-1:0]     dmem_addr;
  logic [DATA_W-1:0]     dmem_wdata;
  logic                  dmem_we;
  logic [DATA_W-1:0]     dmem_rdata;
  logic [IO_CH*IO_W-1:0] io_rdata;
  logic [IO_CH*IO_W-1:0] io_wdata;
  logic [IO_CH-1:0]      io_wstrobe;
  modport slave (
    input  mem_read, mem_write, io_read, io_write, addr_in, wdata, dmem_rdata, io_rdata,
    output r_wdata, stall, dmem_addr, dmem_wdata, dmem_we, io_wdata, io_wstrobe
  );
  modport master (
    output mem_read, mem_write, io_read, io_write, addr_in, wdata, dmem_rdata, io_rdata,
    input  r_wdata, stall, dmem_addr, dmem_wdata, dmem_we, io_wdata, io_wstrobe
  );
endinterface

// File: rtl/io_sync2.sv
// io_sync2: W-bit two-flop synchronizer, reset to 0
module io_sync2 #(parameter int W = 1) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: steers loads/stores to data memory (stalling for wait states) and IO reads/writes to channel registers
// IO_SYNC_EN: when defined, io_rdata passes through a two-flop synchronizer before selection
module mem_io_bridge import mem_io_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int IO_W        = 24,
  parameter int IO_CH       = 4,
  parameter int DMEM_RD_LAT = 1
) (
  input logic clock,
  input logic reset,
  mem_io_bridge_if.slave bus
);
  localparam int CB = ch_bits(IO_CH);
  localparam int PADW = (2**CB) * IO_W;
  localparam logic [2:0] LAT_M1 = 3'(DMEM_RD_LAT - 1);
  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [IO_CH*IO_W-1:0] io_wdata_q, io_wdata_d;
  logic [IO_CH-1:0]      strobe_q, strobe_d;
  logic [IO_CH*IO_W-1:0] io_in;
  logic [PADW-1:0]       io_pad;
  logic [CB-1:0]         ch;
  logic                  ch_ok;
  logic [IO_W-1:0]       sel;
`ifdef IO_SYNC_EN
  io_sync2 #(.W(IO_CH*IO_W)) u_sync (.clock(clock), .reset(reset), .d(bus.io_rdata), .q(io_in));
`else
  assign io_in = bus.io_rdata;
`endif
  assign ch     = bus.addr_in[2 +: CB];
  assign ch_ok  = 32'(ch) < IO_CH;
  // padding to a power-of-two channel count makes out-of-range reads return 0
  assign io_pad = PADW'(io_in);
  assign sel    = io_pad[ch*IO_W +: IO_W];
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    io_wdata_d  = io_wdata_q;
    strobe_d    = '0;
    bus.stall   = 1'b0;
    bus.r_wdata = '0;
    bus.dmem_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_write) bus.dmem_we = 1'b1;
        else if (bus.mem_read) begin
          state_d   = LOAD;
          cnt_d     = LAT_M1;
          bus.stall = 1'b1;
        end else begin
          if (bus.io_write && ch_ok) begin
            io_wdata_d[ch*IO_W +: IO_W] = bus.wdata[IO_W-1:0];
            strobe_d[ch]                = 1'b1;
          end
          if (bus.io_read) bus.r_wdata = DATA_W'(sel);
        end
      end
      LOAD: begin
        bus.stall = 1'b1;
        if (cnt_q == 3'd0) begin
          rdata_d = bus.dmem_rdata;
          state_d = DONE;
        end else cnt_d = cnt_q - 3'd1;
      end
      DONE: begin
        bus.r_wdata = rdata_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      io_wdata_q <= '0;
      strobe_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      io_wdata_q <= io_wdata_d;
      strobe_q   <= strobe_d;
    end
  assign bus.dmem_addr  = bus.addr_in;
  assign bus.dmem_wdata = bus.wdata;
  assign bus.io_wdata   = io_wdata_q;
  assign bus.io_wstrobe = strobe_q;
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed vectors for mem_io_bridge with IO_CH=4/LAT=2 and IO_CH=3/LAT=3 instances
module tb_mem_io_bridge;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;

  mem_io_bridge_if #(.DATA_W(32), .IO_W(24), .IO_CH(4)) bus_a ();
  mem_io_bridge_if #(.DATA_W(32), .IO_W(24), .IO_CH(3)) bus_b ();
  mem_io_bridge #(.DATA_W(32), .IO_W(24), .IO_CH(4), .DMEM_RD_LAT(2)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  mem_io_bridge #(.DATA_W(32), .IO_W(24), .IO_CH(3), .DMEM_RD_LAT(3)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  typedef struct {
    logic        mr, mw, ir, iw;
    logic [31:0] addr, wdata;
    logic [31:0] er;
    logic        es, ewe;
    logic [3:0]  estb;
    logic [95:0] eio;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    bus_a.mem_read = 0; bus_a.mem_write = 0; bus_a.io_read = 0; bus_a.io_write = 0;
  endtask

  task automatic idle_b();
    bus_b.mem_read = 0; bus_b.mem_write = 0; bus_b.io_read = 0; bus_b.io_write = 0;
  endtask

  initial begin
    idle_a(); idle_b();
    bus_a.addr_in = 0; bus_a.wdata = 0; bus_a.dmem_rdata = 32'hDEADBEEF;
    bus_b.addr_in = 0; bus_b.wdata = 0; bus_b.dmem_rdata = 32'h0BADF00D;
    bus_a.io_rdata = 96'hAAAAAA_555555_123456_0F0F0F;
    bus_b.io_rdata = 72'h777777_888888_999999;
    vt[0]  = '{0,0,0,0, 32'h0,        32'h0,        32'h0,        0,0, 4'b0000, 96'h000000_000000_000000_000000};
    vt[1]  = '{0,0,0,1, 32'hFFFFFC08, 32'h00ABCDEF, 32'h0,        0,0, 4'b0100, 96'h000000_ABCDEF_000000_000000};
    vt[2]  = '{0,0,0,0, 32'hFFFFFC08, 32'h0,        32'h0,        0,0, 4'b0000, 96'h000000_ABCDEF_000000_000000};
    vt[3]  = '{0,0,1,0, 32'hFFFFFC14, 32'h0,        32'h00123456, 0,0, 4'b0000, 96'h000000_ABCDEF_000000_000000};
    vt[4]  = '{0,0,0,1, 32'hFFFFFC08, 32'h11223344, 32'h0,        0,0, 4'b0100, 96'h000000_223344_000000_000000};
    vt[5]  = '{0,0,0,1, 32'hFFFFFC08, 32'h00000077, 32'h0,        0,0, 4'b0100, 96'h000000_000077_000000_000000};
    vt[6]  = '{0,0,0,1, 32'hFFFFFC00, 32'hCAFE0001, 32'h0,        0,0, 4'b0001, 96'h000000_000077_000000_FE0001};
    vt[7]  = '{0,1,0,0, 32'h00000100, 32'h00000005, 32'h0,        0,1, 4'b0000, 96'h000000_000077_000000_FE0001};
    vt[8]  = '{1,1,0,0, 32'h00000104, 32'h00000009, 32'h0,        0,1, 4'b0000, 96'h000000_000077_000000_FE0001};
    vt[9]  = '{0,0,1,0, 32'hFFFFFC0C, 32'h0,        32'h00AAAAAA, 0,0, 4'b0000, 96'h000000_000077_000000_FE0001};
    vt[10] = '{0,0,0,0, 32'h0,        32'h0,        32'h0,        0,0, 4'b0000, 96'h000000_000077_000000_FE0001};
    #12;
    chk("reset_stall", {127'b0, bus_a.stall}, 128'd0);
    chk("reset_rdata", {96'b0, bus_a.r_wdata}, 128'd0);
    chk("reset_io_wdata", {32'b0, bus_a.io_wdata}, 128'd0);
    chk("reset_strobe", {124'b0, bus_a.io_wstrobe}, 128'd0);
    @(negedge clock);
    reset = 0;
    repeat (3) tick();

    for (int i = 0; i < 11; i++) begin
      bus_a.mem_read = vt[i].mr; bus_a.mem_write = vt[i].mw;
      bus_a.io_read = vt[i].ir;  bus_a.io_write = vt[i].iw;
      bus_a.addr_in = vt[i].addr; bus_a.wdata = vt[i].wdata;
      #1;
      chk($sformatf("v%0d_r_wdata", i), {96'b0, bus_a.r_wdata}, {96'b0, vt[i].er});
      chk($sformatf("v%0d_stall", i), {127'b0, bus_a.stall}, {127'b0, vt[i].es});
      chk($sformatf("v%0d_dmem_we", i), {127'b0, bus_a.dmem_we}, {127'b0, vt[i].ewe});
      chk($sformatf("v%0d_dmem_addr", i), {96'b0, bus_a.dmem_addr}, {96'b0, vt[i].addr});
      chk($sformatf("v%0d_dmem_wdata", i), {96'b0, bus_a.dmem_wdata}, {96'b0, vt[i].wdata});
      tick();
      chk($sformatf("v%0d_strobe", i), {124'b0, bus_a.io_wstrobe}, {124'b0, vt[i].estb});
      chk($sformatf("v%0d_io_wdata", i), {32'b0, bus_a.io_wdata}, {32'b0, vt[i].eio});
    end
    idle_a();
    tick();

    // load with two wait states
    bus_a.addr_in = 32'h00000200; bus_a.mem_read = 1;
    #1;
    chk("ld_accept_stall", {127'b0, bus_a.stall}, 128'd1);
    tick();
    chk("ld_w1_stall", {127'b0, bus_a.stall}, 128'd1);
    chk("ld_w1_rdata", {96'b0, bus_a.r_wdata}, 128'd0);
    tick();
    chk("ld_w2_stall", {127'b0, bus_a.stall}, 128'd1);
    tick();
    chk("ld_done_stall", {127'b0, bus_a.stall}, 128'd0);
    chk("ld_done_rdata", {96'b0, bus_a.r_wdata}, {96'b0, 32'hDEADBEEF});
    bus_a.mem_read = 0;
    tick();
    chk("ld_idle_stall", {127'b0, bus_a.stall}, 128'd0);
    chk("ld_idle_rdata", {96'b0, bus_a.r_wdata}, 128'd0);

    // io read latency after an input change on ch0
    bus_a.addr_in = 32'hFFFFFC00; bus_a.io_read = 1;
    bus_a.io_rdata = 96'hAAAAAA_555555_123456_C0FFEE;
    #1;
`ifdef IO_SYNC_EN
    chk("sync_t0", {96'b0, bus_a.r_wdata}, {96'b0, 32'h000F0F0F});
    tick();
    chk("sync_t1", {96'b0, bus_a.r_wdata}, {96'b0, 32'h000F0F0F});
    tick();
    chk("sync_t2", {96'b0, bus_a.r_wdata}, {96'b0, 32'h00C0FFEE});
`else
    chk("comb_t0", {96'b0, bus_a.r_wdata}, {96'b0, 32'h00C0FFEE});
`endif
    idle_a();
    tick();

    // out-of-range channel on the three-channel instance
    bus_b.addr_in = 32'hFFFFFC04; bus_b.wdata = 32'h00654321; bus_b.io_write = 1;
    tick();
    chk("b_ch1_strobe", {125'b0, bus_b.io_wstrobe}, {125'b0, 3'b010});
    chk("b_ch1_wdata", {56'b0, bus_b.io_wdata}, {56'b0, 72'h000000_654321_000000});
    bus_b.addr_in = 32'hFFFFFC0C; bus_b.wdata = 32'h00999999;
    tick();
    bus_b.io_write = 0;
    chk("b_oor_strobe", {125'b0, bus_b.io_wstrobe}, 128'd0);
    chk("b_oor_wdata", {56'b0, bus_b.io_wdata}, {56'b0, 72'h000000_654321_000000});
    bus_b.io_read = 1;
    #1;
    chk("b_oor_read", {96'b0, bus_b.r_wdata}, 128'd0);
    bus_b.addr_in = 32'hFFFFFC08;
    #1;
    chk("b_ch2_read", {96'b0, bus_b.r_wdata}, {96'b0, 32'h00777777});
    idle_b();
    tick();

    // reset in the middle of a three-wait-state load
    bus_b.addr_in = 32'h00000300; bus_b.mem_read = 1;
    tick();
    tick();
    chk("b_mid_stall", {127'b0, bus_b.stall}, 128'd1);
    #2;
    reset = 1; bus_b.mem_read = 0;
    #1;
    chk("rst_mid_stall", {127'b0, bus_b.stall}, 128'd0);
    chk("rst_mid_rdata", {96'b0, bus_b.r_wdata}, 128'd0);
    chk("rst_b_io_wdata", {56'b0, bus_b.io_wdata}, 128'd0);
    chk("rst_a_io_wdata", {32'b0, bus_a.io_wdata}, 128'd0);
    @(negedge clock);
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("post_rst_stall%0d", k), {127'b0, bus_b.stall}, 128'd0);
      chk($sformatf("post_rst_rdata%0d", k), {96'b0, bus_b.r_wdata}, 128'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
